// File: rtl/axis_mm2s_s2mm_loopback_pkg.sv
// Shared types for the MM2S->S2MM loopback FIFO.
// Beat layout {tlast, tkeep, tdata} and output FSM states.
package axis_mm2s_s2mm_loopback_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  tlast;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic [DATA_WIDTH-1:0] tdata;
    } axis_beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } out_state_e;

endpackage

// File: rtl/axis_mm2s_s2mm_loopback_if.sv
// AXI-Stream channel bundle (tdata/tkeep/tlast/tvalid/tready).
// master drives payload+valid, slave drives ready.
interface axis_mm2s_s2mm_loopback_if
    import axis_mm2s_s2mm_loopback_pkg::*;
#(
    parameter int DATA_WIDTH = axis_mm2s_s2mm_loopback_pkg::DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/axis_mm2s_s2mm_loopback_fifo_mem.sv
// Loopback FIFO storage: one write port, one read port addressed
// by the top's read-pointer register. Ports: clk, we/waddr/wdata, raddr/rdata.
module axis_mm2s_s2mm_loopback_fifo_mem
    import axis_mm2s_s2mm_loopback_pkg::*;
#(
    parameter int WIDTH = $bits(axis_beat_t),
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is not reset; valid entries are tracked by the top's pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_mm2s_s2mm_loopback.sv
// Loopback FIFO: MM2S stream in (slave), S2MM stream out (master),
// with fill level, resident packet count, pkt_done pulse and in_pkt.
// Ports: axi_aclk, axi_resetn, m_axis_mm2s (slave), s_axis_s2mm (master),
//   fill_level, pkt_count, pkt_done, in_pkt.
// Build option AXIS_LOOPBACK_STORE_FWD_EN: store-and-forward output gating.
module axis_mm2s_s2mm_loopback
    import axis_mm2s_s2mm_loopback_pkg::*;
#(
    parameter int DATA_WIDTH = axis_mm2s_s2mm_loopback_pkg::DATA_WIDTH,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    axis_mm2s_s2mm_loopback_if.slave          m_axis_mm2s,
    axis_mm2s_s2mm_loopback_if.master         s_axis_s2mm,
    output logic [CW-1:0]                     fill_level,
    output logic [CW-1:0]                     pkt_count,
    output logic                              pkt_done,
    output logic                              in_pkt
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int BW = DATA_WIDTH + KW + 1;
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] fill_q;
    logic [CW-1:0] pkt_q;
    logic          rdy_q;
    logic          done_q;
    out_state_e    state_q;
    out_state_e    state_d;

    logic          full;
    logic          empty;
    logic          out_ok;
    logic          out_valid;
    logic          push;
    logic          pop;
    logic          wr_last;
    logic          rd_last;
    logic [BW-1:0] wr_beat;
    logic [BW-1:0] rd_beat;

    assign full  = (fill_q == CW'(DEPTH));
    assign empty = (fill_q == '0);

    // rdy_q keeps tready low throughout reset and for the release cycle.
    assign m_axis_mm2s.tready = rdy_q && !full;

`ifdef AXIS_LOOPBACK_STORE_FWD_EN
    // Hold a packet until its tlast is resident. A full FIFO with no
    // complete packet would deadlock, so full also releases the head;
    // the first non-last read then moves to BURST, which keeps the
    // packet flowing cut-through until its tlast is read.
    assign out_ok = (state_q == BURST) || (pkt_q != '0) || full;
`else
    assign out_ok = 1'b1;
`endif

    assign out_valid = !empty && out_ok;

    assign push    = m_axis_mm2s.tvalid && m_axis_mm2s.tready;
    assign pop     = out_valid && s_axis_s2mm.tready;
    assign wr_last = push && m_axis_mm2s.tlast;
    assign rd_last = pop && rd_beat[BW-1];

    assign wr_beat = {m_axis_mm2s.tlast, m_axis_mm2s.tkeep, m_axis_mm2s.tdata};

    axis_mm2s_s2mm_loopback_fifo_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (axi_aclk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (wr_beat),
        .raddr (rptr_q),
        .rdata (rd_beat)
    );

    // Payload is zeroed while invalid so no stale storage leaks out,
    // including during reset; it is stable whenever tvalid is high.
    assign s_axis_s2mm.tvalid = out_valid;
    assign s_axis_s2mm.tdata  = out_valid ? rd_beat[DATA_WIDTH-1:0] : '0;
    assign s_axis_s2mm.tkeep  = out_valid ? rd_beat[BW-2 -: KW] : '0;
    assign s_axis_s2mm.tlast  = out_valid && rd_beat[BW-1];

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            fill_q <= '0;
        end else if (push && !pop) begin
            fill_q <= fill_q + CW'(1);
        end else if (pop && !push) begin
            fill_q <= fill_q - CW'(1);
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pkt_q <= '0;
        end else if (wr_last && !rd_last) begin
            pkt_q <= pkt_q + CW'(1);
        end else if (rd_last && !wr_last) begin
            pkt_q <= pkt_q - CW'(1);
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= rd_last;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pop && !rd_beat[BW-1]) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rd_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fill_level = fill_q;
    assign pkt_count  = pkt_q;
    assign pkt_done   = done_q;
    assign in_pkt     = (state_q == BURST);

endmodule

// File: tb/tb_axis_mm2s_s2mm_loopback.sv
// Directed scoreboard bench for axis_mm2s_s2mm_loopback.
// Define AXIS_LOOPBACK_STORE_FWD_EN to match a store-and-forward build.
module tb_axis_mm2s_s2mm_loopback;
    import axis_mm2s_s2mm_loopback_pkg::*;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic axi_aclk   = 1'b0;
    logic axi_resetn = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    axis_mm2s_s2mm_loopback_if #(.DATA_WIDTH(DW)) m_axis_mm2s ();
    axis_mm2s_s2mm_loopback_if #(.DATA_WIDTH(DW)) s_axis_s2mm ();

    logic [CW-1:0] fill_level;
    logic [CW-1:0] pkt_count;
    logic          pkt_done;
    logic          in_pkt;

    axis_mm2s_s2mm_loopback #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_resetn  (axi_resetn),
        .m_axis_mm2s (m_axis_mm2s),
        .s_axis_s2mm (s_axis_s2mm),
        .fill_level  (fill_level),
        .pkt_count   (pkt_count),
        .pkt_done    (pkt_done),
        .in_pkt      (in_pkt)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cnt  = 0;
    int inpkt_cnt = 0;
    int n_out     = 0;
    int out_cyc [512];
    int last_in_cyc = 0;

    axis_beat_t exp_q [$];
    axis_beat_t e_b;
    axis_beat_t g_b;

    always @(posedge axi_aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops one expected beat per S2MM handshake.
    always @(negedge axi_aclk) begin
        if (axi_resetn) begin
            if (pkt_done) done_cnt++;
            if (in_pkt) inpkt_cnt++;
            if (s_axis_s2mm.tvalid && s_axis_s2mm.tready) begin
                g_b = {s_axis_s2mm.tlast, s_axis_s2mm.tkeep, s_axis_s2mm.tdata};
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(g_b), 64'h0);
                end else begin
                    e_b = exp_q.pop_front();
                    chk("beat", 64'(g_b), 64'(e_b));
                end
                if (n_out < 512) out_cyc[n_out] = cyc;
                n_out++;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic l);
        int t = 0;
        axis_beat_t b;
        m_axis_mm2s.tdata  = d;
        m_axis_mm2s.tkeep  = k;
        m_axis_mm2s.tlast  = l;
        m_axis_mm2s.tvalid = 1'b1;
        @(negedge axi_aclk);
        while (!m_axis_mm2s.tready && t < 200) begin
            @(negedge axi_aclk);
            t++;
        end
        if (!m_axis_mm2s.tready) begin
            chk("send_timeout", 64'd0, 64'd1);
            m_axis_mm2s.tvalid = 1'b0;
        end else begin
            b = {l, k, d};
            exp_q.push_back(b);
            last_in_cyc = cyc;
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic stop();
        m_axis_mm2s.tvalid = 1'b0;
        m_axis_mm2s.tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        stop();
        repeat (n) begin
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge axi_aclk);
            #1;
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        idle(3);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int in0;
        int b_done;
        int b_inpkt;
        int b_out;

        m_axis_mm2s.tdata  = '0;
        m_axis_mm2s.tkeep  = '0;
        m_axis_mm2s.tlast  = 1'b0;
        m_axis_mm2s.tvalid = 1'b0;
        s_axis_s2mm.tready = 1'b0;

        // Reset state
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("rst_tready", 64'(m_axis_mm2s.tready), 64'd0);
        chk("rst_tvalid", 64'(s_axis_s2mm.tvalid), 64'd0);
        chk("rst_tdata", 64'(s_axis_s2mm.tdata), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("rst_done", 64'(pkt_done), 64'd0);
        chk("rst_inpkt", 64'(in_pkt), 64'd0);
        axi_resetn = 1'b1;
        @(negedge axi_aclk);
        chk("tready_release_cycle", 64'(m_axis_mm2s.tready), 64'd0);
        @(posedge axi_aclk);
        #1;
        chk("tready_rise", 64'(m_axis_mm2s.tready), 64'd1);

        // 8-beat packet, S2MM always ready
        s_axis_s2mm.tready = 1'b1;
        b_done  = done_cnt;
        b_inpkt = inpkt_cnt;
        b_out   = n_out;
        in0     = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h1000_0000 + DW'(i), 4'hF, i == 7);
            if (i == 0) in0 = last_in_cyc;
        end
        stop();
        drain();
        chk("t1_nout", 64'(n_out - b_out), 64'd8);
`ifdef AXIS_LOOPBACK_STORE_FWD_EN
        chk("t1_first_lat", 64'(out_cyc[b_out] - in0), 64'd8);
`else
        chk("t1_first_lat", 64'(out_cyc[b_out] - in0), 64'd1);
`endif
        chk("t1_inpkt_cycles", 64'(inpkt_cnt - b_inpkt), 64'd7);
        chk("t1_done", 64'(done_cnt - b_done), 64'd1);

        // Fill to 16 with S2MM stalled, then release
        s_axis_s2mm.tready = 1'b0;
        b_done = done_cnt;
        for (int i = 0; i < 16; i++) begin
            send(32'h2000_0000 + DW'(i) * 32'h11, KW'(i), i == 15);
        end
        stop();
        chk("t2_full_fill", 64'(fill_level), 64'd16);
        chk("t2_full_tready", 64'(m_axis_mm2s.tready), 64'd0);
        chk("t2_full_pkt", 64'(pkt_count), 64'd1);
        chk("t2_full_tvalid", 64'(s_axis_s2mm.tvalid), 64'd1);
        s_axis_s2mm.tready = 1'b1;
        @(negedge axi_aclk);
        chk("t2_tready_before_pop", 64'(m_axis_mm2s.tready), 64'd0);
        @(posedge axi_aclk);
        #1;
        chk("t2_tready_after_pop", 64'(m_axis_mm2s.tready), 64'd1);
        chk("t2_fill_after_pop", 64'(fill_level), 64'd15);
        drain();
        chk("t2_done", 64'(done_cnt - b_done), 64'd1);
        chk("t2_fill_empty", 64'(fill_level), 64'd0);

        // Steady push+pop at fill_level=5 (single-beat packets)
        s_axis_s2mm.tready = 1'b0;
        b_done  = done_cnt;
        b_inpkt = inpkt_cnt;
        for (int i = 0; i < 5; i++) begin
            send(32'h3000_0000 + DW'(i), 4'hA, 1'b1);
        end
        chk("t3_prefill", 64'(fill_level), 64'd5);
        s_axis_s2mm.tready = 1'b1;
        for (int i = 5; i < 25; i++) begin
            send(32'h3000_0000 + DW'(i), 4'hA, 1'b1);
            chk("t3_fill_steady", 64'(fill_level), 64'd5);
            chk("t3_pkt_steady", 64'(pkt_count), 64'd5);
        end
        stop();
        drain();
        chk("t3_done", 64'(done_cnt - b_done), 64'd25);
        chk("t3_no_burst", 64'(inpkt_cnt - b_inpkt), 64'd0);

        // Reset mid-packet with fill_level=7
        s_axis_s2mm.tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(32'h4000_0000 + DW'(i), 4'hF, 1'b0);
        end
        stop();
        chk("t4_fill7", 64'(fill_level), 64'd7);
        axi_resetn = 1'b0;
        exp_q.delete();
        #1;
        chk("t4_rst_tready", 64'(m_axis_mm2s.tready), 64'd0);
        chk("t4_rst_tvalid", 64'(s_axis_s2mm.tvalid), 64'd0);
        chk("t4_rst_tdata", 64'(s_axis_s2mm.tdata), 64'd0);
        chk("t4_rst_tkeep", 64'(s_axis_s2mm.tkeep), 64'd0);
        chk("t4_rst_fill", 64'(fill_level), 64'd0);
        chk("t4_rst_pkt", 64'(pkt_count), 64'd0);
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
        repeat (2) @(posedge axi_aclk);
        #1;
        chk("t4_post_fill", 64'(fill_level), 64'd0);
        chk("t4_post_tvalid", 64'(s_axis_s2mm.tvalid), 64'd0);
        s_axis_s2mm.tready = 1'b1;
        b_done = done_cnt;
        b_out  = n_out;
        send(32'h5000_0000, 4'h3, 1'b0);
        send(32'h5000_0001, 4'hC, 1'b1);
        stop();
        drain();
        chk("t4_nout", 64'(n_out - b_out), 64'd2);
        chk("t4_done", 64'(done_cnt - b_done), 64'd1);

`ifdef AXIS_LOOPBACK_STORE_FWD_EN
        // Store-and-forward: gaps between beats, output waits for tlast
        s_axis_s2mm.tready = 1'b1;
        b_out = n_out;
        for (int i = 0; i < 4; i++) begin
            send(32'h6000_0000 + DW'(i), 4'hF, i == 3);
            stop();
            if (i < 3) begin
                chk("t5_hold_tvalid", 64'(s_axis_s2mm.tvalid), 64'd0);
                idle(1);
                chk("t5_hold_tvalid_gap", 64'(s_axis_s2mm.tvalid), 64'd0);
            end
        end
        in0 = last_in_cyc;
        drain();
        chk("t5_nout", 64'(n_out - b_out), 64'd4);
        chk("t5_first_after_last", 64'(out_cyc[b_out] - in0), 64'd1);
        chk("t5_back_to_back", 64'(out_cyc[b_out + 3] - out_cyc[b_out]), 64'd3);

        // Store-and-forward: 20-beat packet forces deadlock escape
        b_out  = n_out;
        b_done = done_cnt;
        for (int i = 0; i < 20; i++) begin
            send(32'h7000_0000 + DW'(i), 4'hF, i == 19);
            if (i == 14) begin
                chk("t6_hold_before_full", 64'(s_axis_s2mm.tvalid), 64'd0);
            end
        end
        stop();
        drain();
        chk("t6_nout", 64'(n_out - b_out), 64'd20);
        chk("t6_done", 64'(done_cnt - b_done), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_mm2s_s2mm_loopback.md
Name: axis_mm2s_s2mm_loopback

Overview:
- Loopback FIFO between the DMA's MM2S stream output and its S2MM stream input.
- Accepts beats on the m_axis_mm2s_* channel (this block is the slave) and replays them unchanged (tdata/tkeep/tlast) on the s_axis_s2mm_* channel (this block is the master).
- Lets one DMA instance run MM2S->S2MM memory copies for end-to-end checking. Exposes fill level and packet status.

Parameters:
- DATA_WIDTH, params_pkg::DATA_WIDTH (32): stream data width in bits; tkeep width = DATA_WIDTH/8.
- DEPTH, 16: FIFO entries; power of two, >= 2.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_resetn  in  1  asynchronous active-low reset.
- m_axis_mm2s_tdata  in  DATA_WIDTH  MM2S beat data.
- m_axis_mm2s_tkeep  in  DATA_WIDTH/8  MM2S byte enables.
- m_axis_mm2s_tvalid  in  1  MM2S beat valid.
- m_axis_mm2s_tlast  in  1  MM2S end of packet.
- m_axis_mm2s_tready  out  1  space available (= !full).
- s_axis_s2mm_tdata  out  DATA_WIDTH  replayed data.
- s_axis_s2mm_tkeep  out  DATA_WIDTH/8  replayed byte enables.
- s_axis_s2mm_tvalid  out  1  head beat valid.
- s_axis_s2mm_tlast  out  1  head beat last.
- s_axis_s2mm_tready  in  1  DMA S2MM ready.
- fill_level  out  $clog2(DEPTH+1)  entries occupied.
- pkt_count  out  $clog2(DEPTH+1)  complete packets (tlast beats) resident.
- pkt_done  out  1  one-cycle pulse on an S2MM handshake with tlast=1.
- in_pkt  out  1  output FSM is in BURST.

Behaviour:
- Reset (async assert, sync release): all outputs 0. This includes m_axis_mm2s_tready, so the block does not accept beats while in reset; it rises the first cycle after release. Pointers, counters and FSM are cleared. Reset mid-packet discards all buffered beats with no partial flush.
- Storage entry = {tlast, tkeep, tdata}. Write when m_axis_mm2s_tvalid && m_axis_mm2s_tready. Read when s_axis_s2mm_tvalid && s_axis_s2mm_tready.
- Latency: a beat written in cycle N is presented on s_axis_s2mm_* at N+1 at the earliest. There is no combinational input-to-output path.
- m_axis_mm2s_tready = (fill_level != DEPTH), registered/derived from registered state only. There is no same-cycle pop-to-push bypass: when full, input stays stalled that cycle even if a pop occurs.
- s_axis_s2mm_tvalid = (fill_level != 0), qualified by the Optional Feature. Once asserted, tvalid and payload hold stable until the handshake (AXI-Stream rule).
- Pointers are $clog2(DEPTH) bits and wrap naturally. fill_level: +1 on write only, -1 on read only, unchanged on both.
- pkt_count: +1 on write with tlast, -1 on read with tlast, unchanged on both simultaneously. It never exceeds fill_level.
- Output FSM:
  - IDLE -> BURST on a read with tlast=0.
  - BURST -> IDLE on a read with tlast=1.
  - A single-beat packet (read with tlast=1 in IDLE) stays in IDLE.
  - in_pkt = (state == BURST).
  - pkt_done is registered, asserted the cycle after the tlast read.
- tkeep is passed through unmodified; zero-tkeep beats are forwarded, not dropped.

Optional Feature:
- Macro AXIS_LOOPBACK_STORE_FWD_EN.
- Defined (store-and-forward): in IDLE, s_axis_s2mm_tvalid additionally requires pkt_count != 0. In BURST it is gated only by !empty.
  - Deadlock escape: if full && pkt_count == 0, output is released as cut-through until that packet's tlast is read.
- Undefined: pure cut-through as above; pkt_count is still maintained.

Decomposition:
- params_pkg: DATA_WIDTH, KEEP_WIDTH = DATA_WIDTH/8, typedef axis_beat_t packed {tlast, tkeep, tdata}, typedef enum out_state_e {IDLE, BURST}.
- Sub-module axis_fifo_mem: DEPTH x $bits(axis_beat_t) storage, one write port and one registered-address read port. Control, counters and FSM live in the top.

Test Plan:
- Reset then an 8-beat packet 0x1000_0000..0x1000_0007 (tkeep=0xF, tlast on beat 8) with s2mm ready=1 -> identical beats out, first output one cycle after first input, pkt_done pulses once, in_pkt high for beats 1-7.
- s2mm tready=0 while 16 beats are sent -> tready drops after the 16th, fill_level=16. Release tready -> all 16 drain in order; tready returns the cycle after the first pop.
- Simultaneous push/pop at fill_level=5 over 20 cycles -> fill_level stays 5, pkt_count constant.
- Store-and-forward build, 4-beat packet fed with one idle cycle between beats -> s2mm tvalid stays 0 until the tlast beat is written, then 4 back-to-back beats.
- Store-and-forward build, 20-beat packet with no early tlast, DEPTH=16 -> deadlock escape releases at full, and all 20 beats arrive in order.
- Assert axi_resetn low mid-packet with fill_level=7 -> all outputs 0 immediately. After release, fill_level=0 and a new 2-beat packet passes cleanly.
